// File: rtl/eq_pkg.sv
// Shared equalizer constants and the band-mixer FSM state type.
package eq_pkg;

  localparam int EQ_N_BANDS    = 10;
  localparam int EQ_DATA_W     = 16;
  localparam int EQ_GAIN_W     = 13;
  localparam int EQ_OUT_W      = 24;
  localparam int EQ_FRAC_SHIFT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2,
    ST_HOLD = 2'd3
  } mix_state_t;

  // Worst-case accumulator width: full product, sign of unsigned gain, growth over bands.
  function automatic int acc_width(input int n_bands, input int data_w, input int gain_w);
    return data_w + gain_w + 1 + $clog2(n_bands);
  endfunction

endpackage

// File: rtl/eq_band_mixer_if.sv
// Frame-in / sample-out handshake bundle of the band mixer.
interface eq_band_mixer_if
  import eq_pkg::*;
#(
  parameter int N_BANDS = EQ_N_BANDS,
  parameter int DATA_W  = EQ_DATA_W,
  parameter int GAIN_W  = EQ_GAIN_W,
  parameter int OUT_W   = EQ_OUT_W
) ();

  logic                      s_valid;
  logic                      s_ready;
  logic [N_BANDS*DATA_W-1:0] band_in;
  logic [N_BANDS*GAIN_W-1:0] gain_in;
  logic                      m_valid;
  logic                      m_ready;
  logic [OUT_W-1:0]          audio_out;
  logic                      sat_flag;

  modport master (
    output s_valid, band_in, gain_in, m_ready,
    input  s_ready, m_valid, audio_out, sat_flag
  );

  modport slave (
    input  s_valid, band_in, gain_in, m_ready,
    output s_ready, m_valid, audio_out, sat_flag
  );

endinterface

// File: rtl/eq_shift_sat.sv
// Floor-shift of the mix accumulator and narrowing to the audio width.
// EQ_MIX_SAT_EN selects clamping; otherwise the legacy two's-complement wrap.
module eq_shift_sat #(
  parameter int ACC_W      = 34,
  parameter int OUT_W      = 24,
  parameter int FRAC_SHIFT = 16
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [OUT_W-1:0] out_val,
  output logic                    sat
);

  logic signed [ACC_W-1:0] shifted;

  assign shifted = acc >>> FRAC_SHIFT;

`ifdef EQ_MIX_SAT_EN
  logic [ACC_W-OUT_W:0] top_bits;
  logic                 fits;

  // Value fits when every bit above the output sign bit copies it.
  assign top_bits = shifted[ACC_W-1:OUT_W-1];
  assign fits     = (&top_bits) | ~(|top_bits);

  always_comb begin
    sat     = ~fits;
    out_val = shifted[OUT_W-1:0];
    if (!fits) begin
      out_val = shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                 : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic unused_hi;

  assign unused_hi = ^shifted[ACC_W-1:OUT_W];
  assign out_val   = shifted[OUT_W-1:0];
  assign sat       = 1'b0;
`endif

endmodule

// File: rtl/eq_band_mixer.sv
// Serial band mixer: one shared MAC sums N_BANDS band*gain products per frame.
// Output narrowing/clamping lives in eq_shift_sat (EQ_MIX_SAT_EN).
//
// state   | meaning
// IDLE    | s_ready=1, waiting for a frame
// ACC     | one band*gain product accumulated per cycle
// OUT     | shifted/narrowed result registered, m_valid raised
// HOLD    | result held until m_ready
module eq_band_mixer
  import eq_pkg::*;
#(
  parameter int N_BANDS    = EQ_N_BANDS,
  parameter int DATA_W     = EQ_DATA_W,
  parameter int GAIN_W     = EQ_GAIN_W,
  parameter int OUT_W      = EQ_OUT_W,
  parameter int FRAC_SHIFT = EQ_FRAC_SHIFT
) (
  input logic      clk,
  input logic      rst,
  eq_band_mixer_if.slave bus
);

  localparam int ACC_W = acc_width(N_BANDS, DATA_W, GAIN_W);
  localparam int IDX_W = $clog2(N_BANDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BANDS - 1);

  mix_state_t                state;
  logic [IDX_W-1:0]          idx;
  logic signed [ACC_W-1:0]   acc;
  logic [N_BANDS*DATA_W-1:0] band_r;
  logic [N_BANDS*GAIN_W-1:0] gain_r;
  logic [OUT_W-1:0]          audio_r;
  logic                      sat_r;
  logic                      m_valid_r;
  logic                      s_ready_r;

  logic signed [DATA_W-1:0]  band_sel;
  logic [GAIN_W-1:0]         gain_sel;
  logic signed [ACC_W-1:0]   band_ext;
  logic [ACC_W-1:0]          gain_ext;
  logic signed [ACC_W-1:0]   prod;
  logic [OUT_W-1:0]          shift_val;
  logic                      shift_sat;

  assign band_sel = band_r[idx*DATA_W +: DATA_W];
  assign gain_sel = gain_r[idx*GAIN_W +: GAIN_W];
  assign band_ext = ACC_W'(band_sel);
  assign gain_ext = ACC_W'(gain_sel);
  assign prod     = band_ext * $signed(gain_ext);

  eq_shift_sat #(
    .ACC_W      (ACC_W),
    .OUT_W      (OUT_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_shift_sat (
    .acc     (acc),
    .out_val (shift_val),
    .sat     (shift_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      acc       <= '0;
      audio_r   <= '0;
      sat_r     <= 1'b0;
      m_valid_r <= 1'b0;
      s_ready_r <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.s_valid && s_ready_r) begin
            band_r    <= bus.band_in;
            gain_r    <= bus.gain_in;
            acc       <= '0;
            idx       <= '0;
            s_ready_r <= 1'b0;
            state     <= ST_ACC;
          end
        end
        ST_ACC: begin
          acc <= acc + prod;
          if (idx == IDX_LAST) begin
            idx   <= '0;
            state <= ST_OUT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_OUT: begin
          audio_r   <= shift_val;
          sat_r     <= shift_sat;
          m_valid_r <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.m_ready) begin
            m_valid_r <= 1'b0;
            s_ready_r <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.s_ready   = s_ready_r;
  assign bus.m_valid   = m_valid_r;
  assign bus.audio_out = audio_r;
  assign bus.sat_flag  = sat_r;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Directed bench for eq_band_mixer: FRAC_SHIFT=16 and FRAC_SHIFT=0 instances in lockstep.
module tb_eq_band_mixer;
  import eq_pkg::*;

  localparam int NB = 10;
  localparam int DW = 16;
  localparam int GW = 13;
  localparam int OW = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eq_band_mixer_if #(.N_BANDS(NB), .DATA_W(DW), .GAIN_W(GW), .OUT_W(OW)) bus_a ();
  eq_band_mixer_if #(.N_BANDS(NB), .DATA_W(DW), .GAIN_W(GW), .OUT_W(OW)) bus_b ();

  eq_band_mixer #(.N_BANDS(NB), .DATA_W(DW), .GAIN_W(GW), .OUT_W(OW), .FRAC_SHIFT(16))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  eq_band_mixer #(.N_BANDS(NB), .DATA_W(DW), .GAIN_W(GW), .OUT_W(OW), .FRAC_SHIFT(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    string            name;
    logic [NB*DW-1:0] band;
    logic [NB*GW-1:0] gain;
    logic [OW-1:0]    out_a;
    logic             sat_a;
    logic [OW-1:0]    out_b;
    logic             sat_b;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [NB*DW-1:0] b, input logic [NB*GW-1:0] g,
                       input logic sv, input logic mr);
    bus_a.band_in = b;  bus_b.band_in = b;
    bus_a.gain_in = g;  bus_b.gain_in = g;
    bus_a.s_valid = sv; bus_b.s_valid = sv;
    bus_a.m_ready = mr; bus_b.m_ready = mr;
  endtask

  function automatic logic [NB*DW-1:0] fill_band(input logic [DW-1:0] v);
    logic [NB*DW-1:0] r;
    for (int k = 0; k < NB; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [NB*GW-1:0] fill_gain(input logic [GW-1:0] v);
    logic [NB*GW-1:0] r;
    for (int k = 0; k < NB; k++) r[k*GW +: GW] = v;
    return r;
  endfunction

  // Accept a frame with m_ready=1; check latency, busy s_ready, both results, release.
  task automatic run_frame(input vec_t v);
    int lat;
    logic busy_bad;
    lat = -1;
    busy_bad = 1'b0;
    @(negedge clk);
    drive(v.band, v.gain, 1'b1, 1'b1);
    @(posedge clk);
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      drive(~v.band, ~v.gain, 1'b0, 1'b1);
      if (bus_a.m_valid === 1'b1) begin
        lat = c;
        break;
      end
      if (bus_a.s_ready !== 1'b0 || bus_b.s_ready !== 1'b0) busy_bad = 1'b1;
    end
    chk({v.name, "_latency"}, 32'(lat), 32'(NB + 1));
    if (lat < 0) return;
    chk({v.name, "_busy_s_ready"}, {31'd0, busy_bad}, 32'd0);
    chk({v.name, "_b_m_valid"}, {31'd0, bus_b.m_valid}, 32'd1);
    chk({v.name, "_out_a"}, 32'(bus_a.audio_out), 32'(v.out_a));
    chk({v.name, "_sat_a"}, {31'd0, bus_a.sat_flag}, {31'd0, v.sat_a});
    chk({v.name, "_out_b"}, 32'(bus_b.audio_out), 32'(v.out_b));
    chk({v.name, "_sat_b"}, {31'd0, bus_b.sat_flag}, {31'd0, v.sat_b});
    @(negedge clk);
    chk({v.name, "_release"}, {30'd0, bus_a.m_valid, bus_a.s_ready}, 32'b01);
  endtask

  initial begin
    int nb [NB] = '{1000, 2000, 1500, 1200, 1100, 1300, 1400, 1250, 1350, 1450};
    int mv;
    logic bp_bad_out, bp_bad_ctl, abort_bad;

    vecs[0].name = "nominal";
    for (int k = 0; k < NB; k++) begin
      vecs[0].band[k*DW +: DW] = DW'(nb[k]);
      vecs[0].gain[k*GW +: GW] = GW'(k + 2);
    end
    vecs[0].out_a = 24'h000001; vecs[0].sat_a = 1'b0;
    vecs[0].out_b = 24'h015630; vecs[0].sat_b = 1'b0;

    vecs[1].name = "neg_floor";
    vecs[1].band = '0; vecs[1].gain = '0;
    vecs[1].band[DW-1:0] = 16'hFFFF; vecs[1].gain[GW-1:0] = 13'd1;
    vecs[1].out_a = 24'hFFFFFF; vecs[1].sat_a = 1'b0;
    vecs[1].out_b = 24'hFFFFFF; vecs[1].sat_b = 1'b0;

    vecs[2].name = "pos_full";
    vecs[2].band = fill_band(16'h7FFF); vecs[2].gain = fill_gain(13'h1FFF);
    vecs[2].out_a = 24'h009FF9; vecs[2].sat_a = 1'b0;

    vecs[3].name = "neg_full";
    vecs[3].band = fill_band(16'h8000); vecs[3].gain = fill_gain(13'h1FFF);
    vecs[3].out_a = 24'hFF6005; vecs[3].sat_a = 1'b0;

    vecs[4].name = "single_max";
    vecs[4].band = '0; vecs[4].gain = '0;
    vecs[4].band[DW-1:0] = 16'h7FFF; vecs[4].gain[GW-1:0] = 13'h1FFF;
    vecs[4].out_a = 24'h000FFF; vecs[4].sat_a = 1'b0;

`ifdef EQ_MIX_SAT_EN
    vecs[2].out_b = 24'h7FFFFF; vecs[2].sat_b = 1'b1;
    vecs[3].out_b = 24'h800000; vecs[3].sat_b = 1'b1;
    vecs[4].out_b = 24'h7FFFFF; vecs[4].sat_b = 1'b1;
`else
    vecs[2].out_b = 24'hF9C00A; vecs[2].sat_b = 1'b0;
    vecs[3].out_b = 24'h050000; vecs[3].sat_b = 1'b0;
    vecs[4].out_b = 24'hFF6001; vecs[4].sat_b = 1'b0;
`endif

    vecs[5].name = "zero_gain";
    vecs[5].band = fill_band(16'd12345); vecs[5].gain = '0;
    vecs[5].out_a = 24'h000000; vecs[5].sat_a = 1'b0;
    vecs[5].out_b = 24'h000000; vecs[5].sat_b = 1'b0;

    vecs[6].name = "all_neg";
    vecs[6].band = fill_band(16'hFC18); vecs[6].gain = fill_gain(13'd1);
    vecs[6].out_a = 24'hFFFFFF; vecs[6].sat_a = 1'b0;
    vecs[6].out_b = 24'hFFD8F0; vecs[6].sat_b = 1'b0;

    vecs[7].name = "last_band";
    vecs[7].band = '0; vecs[7].gain = '0;
    vecs[7].band[9*DW +: DW] = 16'd1000; vecs[7].gain[9*GW +: GW] = 13'd7;
    vecs[7].out_a = 24'h000000; vecs[7].sat_a = 1'b0;
    vecs[7].out_b = 24'h001B58; vecs[7].sat_b = 1'b0;

    // Reset with random inputs for two edges.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive({$urandom, $urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom, $urandom},
            1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    chk("rst_audio_out", 32'(bus_a.audio_out), 32'd0);
    chk("rst_m_valid", {30'd0, bus_a.m_valid, bus_b.m_valid}, 32'd0);
    chk("rst_sat_flag", {30'd0, bus_a.sat_flag, bus_b.sat_flag}, 32'd0);
    rst = 1'b0;
    drive('0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("rst_s_ready", {30'd0, bus_a.s_ready, bus_b.s_ready}, 32'b11);

    for (int v = 0; v < NVEC; v++) run_frame(vecs[v]);

    // Backpressure: hold m_ready low, wiggle inputs and s_valid while the result waits.
    @(negedge clk);
    drive(vecs[0].band, vecs[0].gain, 1'b1, 1'b0);
    @(posedge clk);
    mv = -1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      drive(vecs[2].band, vecs[2].gain, 1'b0, 1'b0);
      if (bus_a.m_valid === 1'b1) begin
        mv = c;
        break;
      end
    end
    chk("bp_latency", 32'(mv), 32'(NB + 1));
    bp_bad_out = 1'b0;
    bp_bad_ctl = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive({$urandom, $urandom, $urandom, $urandom, $urandom}, vecs[2].gain, 1'b1, 1'b0);
      @(negedge clk);
      if (bus_a.audio_out !== 24'h000001 || bus_b.audio_out !== 24'h015630) bp_bad_out = 1'b1;
      if (bus_a.m_valid !== 1'b1 || bus_a.s_ready !== 1'b0) bp_bad_ctl = 1'b1;
    end
    chk("bp_out_stable", {31'd0, bp_bad_out}, 32'd0);
    chk("bp_ctl_stable", {31'd0, bp_bad_ctl}, 32'd0);
    drive(vecs[2].band, vecs[2].gain, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp_release", {30'd0, bus_a.m_valid, bus_a.s_ready}, 32'b01);
    chk("bp_no_new_frame", 32'(bus_a.audio_out), 32'h000001);
    @(negedge clk);
    chk("bp_idle_after", {30'd0, bus_a.m_valid, bus_a.s_ready}, 32'b01);

    // Abort: reset lands on the 5th ACC edge (E5).
    @(negedge clk);
    drive(vecs[2].band, vecs[2].gain, 1'b1, 1'b1);
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(vecs[2].band, vecs[2].gain, 1'b0, 1'b1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_idle", {30'd0, bus_a.m_valid, bus_a.s_ready}, 32'b01);
    chk("abort_out_cleared", 32'(bus_a.audio_out), 32'd0);
    abort_bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus_a.m_valid !== 1'b0 || bus_b.m_valid !== 1'b0) abort_bad = 1'b1;
    end
    chk("abort_no_output", {31'd0, abort_bad}, 32'd0);
    run_frame(vecs[0]);
    run_frame(vecs[6]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
